// File: rtl/bcd_serial_conv.sv
// bcd_serial_conv: serial binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Valid/ready handshake on both sides: one conversion engine plus one output holding register.
// Optional feature: define BCD_SERIAL_BLANK_EN to add the out_blank leading-zero blanking output.

module bcd_serial_conv #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_ovf
`ifdef BCD_SERIAL_BLANK_EN
   ,
   output logic [DIGITS-1:0]     out_blank
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic [WIDTH-1:0]    shreg;
   logic [4*DIGITS-1:0] bcd;
   logic                ovf;

   logic [4*DIGITS-1:0] bcd_adj;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic                ovf_nxt;
   logic [4*DIGITS-1:0] res_bcd;
   logic                res_ovf;
   logic                accept;
   logic                done;
   logic                out_free;
   logic                load;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign done     = (state == SHIFT) && (cnt == '0);
   assign out_free = !out_valid || out_ready;
   assign load     = (done || (state == HOLD)) && out_free;

   // Add-3 correction on every digit in parallel from pre-shift values, then form the shifted result.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      bcd_adj = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
      end
      bcd_nxt = {bcd_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
      // The bit leaving the top digit means the value needs more than DIGITS digits.
      ovf_nxt = ovf | bcd_adj[4*DIGITS-1];
   end

   // The result to publish: fresh from the final shift, or the one parked while in HOLD.
   always_comb begin
      res_bcd = bcd_nxt;
      res_ovf = ovf_nxt;
      if (state == HOLD) begin
         res_bcd = bcd;
         res_ovf = ovf;
      end
   end

`ifdef BCD_SERIAL_BLANK_EN
   logic [DIGITS:0]   zero_above;
   logic [DIGITS-1:0] blank_nxt;

   // Leading-zero flags: digit i blanks when it and every higher digit are zero; digit 0 never blanks.
   always_comb begin
      zero_above[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] && (res_bcd[4*i +: 4] == 4'd0);
      end
      blank_nxt = {zero_above[DIGITS-1:1], 1'b0};
   end
`endif

   // Conversion engine: accept in IDLE, WIDTH shift cycles, park the result in HOLD if the output is busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         bcd   <= '0;
         ovf   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= in_data;
                  bcd   <= '0;
                  ovf   <= 1'b0;
                  cnt   <= CNT_LOAD;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               shreg <= shreg << 1;
               bcd   <= bcd_nxt;
               ovf   <= ovf_nxt;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= out_free ? IDLE : HOLD;
               end
            end
            HOLD: begin
               if (out_free) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output holding register: load a finished result, otherwise drop valid once the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_bcd   <= '0;
         out_ovf   <= 1'b0;
`ifdef BCD_SERIAL_BLANK_EN
         out_blank <= '0;
`endif
      end else if (load) begin
         out_valid <= 1'b1;
         out_bcd   <= res_bcd;
         out_ovf   <= res_ovf;
`ifdef BCD_SERIAL_BLANK_EN
         out_blank <= blank_nxt;
`endif
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/bcd_serial_conv.md
Name: bcd_serial_conv

Overview:
- Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Wide values (counters, ADC samples) are converted for 7-segment/ASCII display paths without a large combinational add3 array.
- A valid/ready handshake on input and output; one conversion engine, one output holding register.

Parameters:
- WIDTH, 16, binary input width (>=4).
- DIGITS, 5, BCD digits produced; 5 covers WIDTH=16 (max 65535).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  converter accepts in_data this cycle.
- in_data  input  WIDTH  unsigned binary value.
- out_valid  output  1  out_bcd/out_ovf hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 (ones) at [3:0].
- out_ovf  output  1  value did not fit in DIGITS digits.

Behaviour:
- Reset (async, active-high): state=IDLE, bit counter=0, shift/BCD working regs=0, out_valid=0, out_bcd=0, out_ovf=0, in_ready=1 once rst deasserts.
- States: IDLE, SHIFT, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, load in_data into shift reg, clear BCD accumulator and sticky overflow, counter=WIDTH-1, go SHIFT.
- SHIFT: in_ready=0. Each cycle: every digit >=5 gets +3 (all digits corrected in parallel, from pre-shift values); then {BCD,shift} shifts left 1; bit shifted out of top digit ORs into sticky overflow. Counter decrements; after the cycle with counter==0 (exactly WIDTH SHIFT cycles), conversion is complete.
- Completion: if output register empty (out_valid=0), or being drained this cycle (out_valid&&out_ready), load out_bcd/out_ovf, set out_valid, go IDLE. Otherwise go HOLD.
- HOLD: in_ready=0; result kept internally; on the cycle output register frees (out_valid&&out_ready, or out_valid=0), load it, set out_valid, go IDLE.
- Latency: acceptance edge E -> out_valid high after edge E+WIDTH (no back-pressure). Throughput: one result per WIDTH+1 cycles.
- Output: out_valid falls on the edge where out_valid&&out_ready, unless a new result loads on that same edge (stays 1, new data). out_bcd/out_ovf stable while out_valid&&!out_ready.
- Input may be accepted while previous result still waits in the output register.
- in_data sampled only on acceptance; changes afterward ignored. in_valid while in_ready=0 is ignored (no data lost; producer must hold).
- On out_ovf=1, out_bcd holds the low DIGITS digits of the value (modulo 10^DIGITS).
- in_data=0 -> all digits 0, out_ovf=0. Max value 2^WIDTH-1 must convert exactly when DIGITS sufficient.
- rst mid-SHIFT or mid-HOLD: conversion and pending result discarded, outputs to reset values asynchronously.

Optional Feature:
- Macro BCD_SERIAL_BLANK_EN.
- Defined: extra output out_blank (DIGITS bits), registered with out_bcd; bit i=1 when digit i and all higher digits are 0, for i>=1; bit 0 always 0 (a zero value displays "0").
- Not defined: out_blank port absent; no blanking logic.

Test Plan:
- Reset, in_data=16'd0, out_ready=1 -> out_bcd=20'h00000, out_ovf=0, out_valid exactly 16 cycles after acceptance edge.
- in_data=16'd65535 -> out_bcd=20'h65535, out_ovf=0; in_data=16'd1234 -> 20'h01234.
- WIDTH=8, DIGITS=2, in_data=8'd255 -> out_ovf=1, out_bcd=8'h55.
- out_ready=0, send 100 then 200 -> first holds 20'h00100 stable; engine enters HOLD, in_ready=0; raise out_ready -> 20'h00100 then 20'h00200, no loss/duplication.
- Assert rst at SHIFT cycle 7 of 9999 -> out_valid=0, in_ready=1 after release; next value 42 -> 20'h00042.
- BCD_SERIAL_BLANK_EN defined: 42 -> out_blank=5'b11100; 0 -> 5'b11110; 65535 -> 5'b00000.
